delay_arbiter: RTL and testbench

- Shares one CBITS-wide delay counter among NREQ requesters.
- Each requester asks for a timed delay. The block grants the shared counter round-robin, counts the delay, then pulses done to the owner.
- Sits between the protocol blocks that need fixed-length waits and the single timer resource, so each block does not instantiate its own 15-bit counter.

---
 rtl/delay_arbiter.sv | 176 +++++++++++++++++
 tb/tb_delay_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one delay counter among NREQ requesters.
// Optional macro DELAY_ARB_LEN_EN adds a per-grant len input that replaces DELAY.
module delay_arbiter #(
  parameter int NREQ  = 4,
  parameter int CBITS = 15,
  parameter int DELAY = 22500
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
`ifdef DELAY_ARB_LEN_EN
  input  logic [CBITS-1:0] len,
`endif
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             abort,
  output logic             busy,
  output logic [CBITS-1:0] cnt
);

  localparam int PTRW = $clog2(NREQ);

  if (DELAY == 0 || DELAY >= (64'd1 << CBITS)) begin : g_bad_delay
    $error("delay_arbiter: DELAY must be in 1 .. 2**CBITS-1");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("delay_arbiter: NREQ must be in 2 .. 8");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             abort_q, abort_d;
  logic             busy_q, busy_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [PTRW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [PTRW-1:0]  owner_q, owner_d;
  logic [CBITS-1:0] term_cnt;

`ifdef DELAY_ARB_LEN_EN
  logic [CBITS-1:0] term_q, term_d;
  assign term_cnt = term_q;
`else
  assign term_cnt = CBITS'(DELAY);
`endif

  // Rotate requests so bit 0 is the rr_ptr requester, then take the lowest set bit.
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [NREQ-1:0]   first_hot;
  logic [PTRW-1:0]   win_off;
  logic [PTRW:0]     win_sum;
  logic [PTRW-1:0]   win_idx;
  logic [PTRW-1:0]   owner_next;
  logic              owner_req;

  assign req_dbl   = {req, req};
  assign req_rot   = req_dbl[NREQ-1:0] >> rr_ptr_q | req_dbl[2*NREQ-1:NREQ] << (NREQ - int'(rr_ptr_q));
  assign first_hot = req_rot & (~req_rot + NREQ'(1));

  always_comb begin
    win_off = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (first_hot[i]) win_off = PTRW'(i);
    end
  end

  always_comb begin
    win_sum = {1'b0, rr_ptr_q} + {1'b0, win_off};
    if (win_sum >= (PTRW+1)'(NREQ)) win_sum = win_sum - (PTRW+1)'(NREQ);
  end

  assign win_idx    = win_sum[PTRW-1:0];
  assign owner_next = (owner_q == PTRW'(NREQ-1)) ? '0 : owner_q + PTRW'(1);
  assign owner_req  = |(req & gnt_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    abort_d  = 1'b0;
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
`ifdef DELAY_ARB_LEN_EN
    term_d   = term_q;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        cnt_d  = '0;
        if (|req) begin
          state_d = ST_COUNT;
          gnt_d   = NREQ'(1) << win_idx;
          busy_d  = 1'b1;
          owner_d = win_idx;
`ifdef DELAY_ARB_LEN_EN
          term_d  = len;
`endif
        end
      end
      ST_COUNT: begin
        // An owner drop wins over expiry on the same edge.
        if (!owner_req) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b0;
          abort_d  = 1'b1;
          rr_ptr_d = owner_next;
        end else if (cnt_q == term_cnt) begin
          state_d = ST_DONE;
          done_d  = gnt_q;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        cnt_d    = '0;
        busy_d   = 1'b0;
        rr_ptr_d = owner_next;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        cnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
`ifdef DELAY_ARB_LEN_EN
      term_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
`ifdef DELAY_ARB_LEN_EN
      term_q   <= term_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign abort = abort_q;
  assign busy  = busy_q;
  assign cnt   = cnt_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// Scoreboard bench for delay_arbiter with DELAY=5, NREQ=4; len scenario runs
// only when DELAY_ARB_LEN_EN is defined.
module tb_delay_arbiter;
  localparam int NREQ  = 4;
  localparam int CBITS = 15;
  localparam int DELAY = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  req = '0;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  done;
  logic             abort;
  logic             busy;
  logic [CBITS-1:0] cnt;
`ifdef DELAY_ARB_LEN_EN
  logic [CBITS-1:0] len = '0;
`endif

  delay_arbiter #(.NREQ(NREQ), .CBITS(CBITS), .DELAY(DELAY)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
`ifdef DELAY_ARB_LEN_EN
    .len   (len),
`endif
    .gnt   (gnt),
    .done  (done),
    .abort (abort),
    .busy  (busy),
    .cnt   (cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             rst;
    logic [NREQ-1:0]  req;
    logic [CBITS-1:0] len;
  } stim_t;

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic             abort;
    logic             busy;
    logic [CBITS-1:0] cnt;
  } obs_t;

  int    checks = 0;
  int    errors = 0;
  logic  mon_en = 1'b0;
  stim_t stim_q[$];
  obs_t  exp_q[$];

  function automatic obs_t mk(input logic [NREQ-1:0] g, input logic [NREQ-1:0] d,
                              input logic a, input int c);
    mk = {g, d, a, (g != '0), CBITS'(c)};
  endfunction

  task automatic push(input logic r, input logic [NREQ-1:0] q, input int l, input obs_t e);
    stim_t s;
    s = {r, q, CBITS'(l)};
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic apply(input stim_t s);
    rst = s.rst;
    req = s.req;
`ifdef DELAY_ARB_LEN_EN
    len = s.len;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply({1'b1, 4'b0000, 15'd0});
    apply({1'b1, 4'b0000, 15'd0});
    mon_en = 1'b1;
  endtask

  // Invariants sampled on the falling edge, away from output updates.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (!(gnt == '0 || $onehot(gnt)) || (done != '0 && done !== gnt) ||
          (done != '0 && abort) || cnt > CBITS'(DELAY) || busy !== (gnt != '0)) begin
        errors++;
        $display("FAIL invariant t=%0t: gnt=%b done=%b abort=%b busy=%b cnt=%0d",
                 $time, gnt, done, abort, busy, cnt);
      end
    end
  end

  task automatic test_reset();
    obs_t o, e;
    push(1, 4'b1111, 0, mk(4'b0000, 4'b0000, 0, 0));
    push(1, 4'b1111, 0, mk(4'b0000, 4'b0000, 0, 0));
    push(0, 4'b1111, 0, mk(4'b0001, 4'b0000, 0, 0));
    for (int n = 1; stim_q.size() != 0; n++) begin
      apply(stim_q.pop_front());
      mon_en = 1'b1;
      e = exp_q.pop_front();
      o = {gnt, done, abort, busy, cnt};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset e%0d: got gnt=%b done=%b abort=%b busy=%b cnt=%0d, expected gnt=%b done=%b abort=%b busy=%b cnt=%0d",
                 n, o.gnt, o.done, o.abort, o.busy, o.cnt, e.gnt, e.done, e.abort, e.busy, e.cnt);
      end else $display("reset e%0d: gnt=%b done=%b abort=%b cnt=%0d", n, o.gnt, o.done, o.abort, o.cnt);
    end
  endtask

  task automatic test_single();
    obs_t o, e;
    do_reset();
    for (int k = 0; k <= DELAY; k++) push(0, 4'b0001, 0, mk(4'b0001, 4'b0000, 0, k));
    push(0, 4'b0001, 0, mk(4'b0001, 4'b0001, 0, DELAY));
    push(0, 4'b0001, 0, mk(4'b0000, 4'b0000, 0, 0));
    push(0, 4'b0001, 0, mk(4'b0001, 4'b0000, 0, 0));
    push(0, 4'b0000, 0, mk(4'b0000, 4'b0000, 1, 0));
    for (int n = 1; stim_q.size() != 0; n++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      o = {gnt, done, abort, busy, cnt};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single e%0d: got gnt=%b done=%b abort=%b busy=%b cnt=%0d, expected gnt=%b done=%b abort=%b busy=%b cnt=%0d",
                 n, o.gnt, o.done, o.abort, o.busy, o.cnt, e.gnt, e.done, e.abort, e.busy, e.cnt);
      end else $display("single e%0d: gnt=%b done=%b abort=%b cnt=%0d", n, o.gnt, o.done, o.abort, o.cnt);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g[$];
    logic [NREQ-1:0] eg;
    logic [NREQ-1:0] prev;
    int              idle_run;
    logic            first;
    do_reset();
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    prev = '0;
    idle_run = 0;
    first = 1'b1;
    for (int cyc = 0; cyc < 60 && exp_g.size() != 0; cyc++) begin
      apply({1'b0, 4'b1111, 15'd0});
      if (gnt != '0 && prev == '0) begin
        eg = exp_g.pop_front();
        checks++;
        if (gnt !== eg || (!first && idle_run != 1)) begin
          errors++;
          $display("FAIL round_robin: got gnt=%b after %0d idle cycles, expected gnt=%b after 1",
                   gnt, idle_run, eg);
        end else $display("round_robin: gnt=%b after %0d idle cycles", gnt, idle_run);
        first = 1'b0;
      end
      idle_run = (gnt == '0) ? idle_run + 1 : 0;
      prev = gnt;
    end
    checks++;
    if (exp_g.size() != 0) begin
      errors++;
      $display("FAIL round_robin timeout: %0d grants missing, expected 0", exp_g.size());
    end
  endtask

  task automatic test_abort();
    obs_t o, e;
    do_reset();
    for (int k = 0; k <= 3; k++) push(0, 4'b0100, 0, mk(4'b0100, 4'b0000, 0, k));
    push(0, 4'b0000, 0, mk(4'b0000, 4'b0000, 1, 0));
    push(0, 4'b1011, 0, mk(4'b1000, 4'b0000, 0, 0));
    push(0, 4'b1011, 0, mk(4'b1000, 4'b0000, 0, 1));
    for (int n = 1; stim_q.size() != 0; n++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      o = {gnt, done, abort, busy, cnt};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort e%0d: got gnt=%b done=%b abort=%b busy=%b cnt=%0d, expected gnt=%b done=%b abort=%b busy=%b cnt=%0d",
                 n, o.gnt, o.done, o.abort, o.busy, o.cnt, e.gnt, e.done, e.abort, e.busy, e.cnt);
      end else $display("abort e%0d: gnt=%b done=%b abort=%b cnt=%0d", n, o.gnt, o.done, o.abort, o.cnt);
    end
  endtask

  task automatic test_abort_at_terminal();
    obs_t o, e;
    do_reset();
    for (int k = 0; k <= DELAY; k++) push(0, 4'b0001, 0, mk(4'b0001, 4'b0000, 0, k));
    push(0, 4'b0000, 0, mk(4'b0000, 4'b0000, 1, 0));
    push(0, 4'b0000, 0, mk(4'b0000, 4'b0000, 0, 0));
    push(0, 4'b0011, 0, mk(4'b0010, 4'b0000, 0, 0));
    for (int n = 1; stim_q.size() != 0; n++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      o = {gnt, done, abort, busy, cnt};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL abort_terminal e%0d: got gnt=%b done=%b abort=%b busy=%b cnt=%0d, expected gnt=%b done=%b abort=%b busy=%b cnt=%0d",
                 n, o.gnt, o.done, o.abort, o.busy, o.cnt, e.gnt, e.done, e.abort, e.busy, e.cnt);
      end else $display("abort_terminal e%0d: gnt=%b done=%b abort=%b cnt=%0d", n, o.gnt, o.done, o.abort, o.cnt);
    end
  endtask

  task automatic test_reset_mid_count();
    obs_t o, e;
    do_reset();
    for (int k = 0; k <= 3; k++) push(0, 4'b0001, 0, mk(4'b0001, 4'b0000, 0, k));
    push(1, 4'b0011, 0, mk(4'b0000, 4'b0000, 0, 0));
    push(0, 4'b0011, 0, mk(4'b0001, 4'b0000, 0, 0));
    push(0, 4'b0011, 0, mk(4'b0001, 4'b0000, 0, 1));
    for (int n = 1; stim_q.size() != 0; n++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      o = {gnt, done, abort, busy, cnt};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid e%0d: got gnt=%b done=%b abort=%b busy=%b cnt=%0d, expected gnt=%b done=%b abort=%b busy=%b cnt=%0d",
                 n, o.gnt, o.done, o.abort, o.busy, o.cnt, e.gnt, e.done, e.abort, e.busy, e.cnt);
      end else $display("reset_mid e%0d: gnt=%b done=%b abort=%b cnt=%0d", n, o.gnt, o.done, o.abort, o.cnt);
    end
  endtask

  task automatic test_drop_in_done();
    obs_t o, e;
    do_reset();
    for (int k = 0; k <= DELAY; k++) push(0, 4'b0001, 0, mk(4'b0001, 4'b0000, 0, k));
    push(0, 4'b0001, 0, mk(4'b0001, 4'b0001, 0, DELAY));
    push(0, 4'b0010, 0, mk(4'b0000, 4'b0000, 0, 0));
    push(0, 4'b0010, 0, mk(4'b0010, 4'b0000, 0, 0));
    for (int n = 1; stim_q.size() != 0; n++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      o = {gnt, done, abort, busy, cnt};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL drop_in_done e%0d: got gnt=%b done=%b abort=%b busy=%b cnt=%0d, expected gnt=%b done=%b abort=%b busy=%b cnt=%0d",
                 n, o.gnt, o.done, o.abort, o.busy, o.cnt, e.gnt, e.done, e.abort, e.busy, e.cnt);
      end else $display("drop_in_done e%0d: gnt=%b done=%b abort=%b cnt=%0d", n, o.gnt, o.done, o.abort, o.cnt);
    end
  endtask

`ifdef DELAY_ARB_LEN_EN
  task automatic test_len();
    obs_t o, e;
    do_reset();
    push(0, 4'b0001, 0, mk(4'b0001, 4'b0000, 0, 0));
    push(0, 4'b0001, 0, mk(4'b0001, 4'b0001, 0, 0));
    push(0, 4'b0001, 3, mk(4'b0000, 4'b0000, 0, 0));
    push(0, 4'b0001, 3, mk(4'b0001, 4'b0000, 0, 0));
    push(0, 4'b0001, 7, mk(4'b0001, 4'b0000, 0, 1));
    push(0, 4'b0001, 7, mk(4'b0001, 4'b0000, 0, 2));
    push(0, 4'b0001, 7, mk(4'b0001, 4'b0000, 0, 3));
    push(0, 4'b0001, 7, mk(4'b0001, 4'b0001, 0, 3));
    push(0, 4'b0000, 7, mk(4'b0000, 4'b0000, 0, 0));
    for (int n = 1; stim_q.size() != 0; n++) begin
      apply(stim_q.pop_front());
      e = exp_q.pop_front();
      o = {gnt, done, abort, busy, cnt};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL len e%0d: got gnt=%b done=%b abort=%b busy=%b cnt=%0d, expected gnt=%b done=%b abort=%b busy=%b cnt=%0d",
                 n, o.gnt, o.done, o.abort, o.busy, o.cnt, e.gnt, e.done, e.abort, e.busy, e.cnt);
      end else $display("len e%0d: gnt=%b done=%b abort=%b cnt=%0d", n, o.gnt, o.done, o.abort, o.cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_abort_at_terminal();
    test_reset_mid_count();
    test_drop_in_done();
`ifdef DELAY_ARB_LEN_EN
    test_len();
`endif
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
